// File: rtl/ex_wb_stage.sv
// ex_wb_stage: EX->WB pipeline stage. Captures ALU result / WB control,
// holds it across WB back-pressure and drives the register-file write port
// plus the hazard unit's forwarding tap.
// Build option: WB_SKID_EN (defined -> 2-entry skid buffer with registered
// in_ready; undefined -> single entry with combinational in_ready).
module ex_wb_stage #(
    parameter int XLEN  = 32,
    parameter int RD_W  = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_R,
    input  logic             in_zero,
    input  logic [XLEN-1:0]  in_aux,
    input  logic             in_wbsel,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_regwrite,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_wdata,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_we,
    output logic             out_zero,
    output logic             fwd_valid,
    output logic [RD_W-1:0]  fwd_rd,
    output logic [XLEN-1:0]  fwd_data,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    // Held entry: WB mux already resolved, write-enable already folded with rd!=0.
    typedef struct packed {
        logic [XLEN-1:0] wdata;
        logic [RD_W-1:0] rd;
        logic            we;
        logic            zero;
    } entry_t;

    state_e           state_q, state_d;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    entry_t           in_entry;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             accept, retire;

    // Incoming entry with writeback source selected at capture time.
    always_comb begin
        in_entry       = '0;
        in_entry.wdata = in_wbsel ? in_aux : in_R;
        in_entry.rd    = in_rd;
        in_entry.we    = in_regwrite & (in_rd != '0);
        in_entry.zero  = in_zero;
    end

    // Handshake: in_ready is a pure state decode in skid mode (no path from out_ready).
    always_comb begin
        out_valid = (state_q != EMPTY);
`ifdef WB_SKID_EN
        in_ready  = (state_q != TWO);
`else
        in_ready  = !out_valid | out_ready;
`endif
        accept    = in_valid & in_ready;
        retire    = out_valid & out_ready;
    end

    // Occupancy FSM next state and payload movement; flush dominates everything.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = in_entry;
                    state_d = ONE;
                end
            end
            ONE: begin
`ifdef WB_SKID_EN
                if (accept && !retire) begin
                    skid_d  = in_entry;
                    state_d = TWO;
                end else if (accept && retire) begin
                    head_d  = in_entry;
                end else if (retire) begin
                    state_d = EMPTY;
                end
`else
                if (accept) begin
                    head_d  = in_entry;
                end else if (retire) begin
                    state_d = EMPTY;
                end
`endif
            end
            TWO: begin
                if (retire) begin
                    head_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Back-pressure counter: counts refused EX cycles, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_valid && !in_ready && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // State, payload and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            head_q      <= '0;
            skid_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            skid_q      <= skid_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Outputs always show the head entry; write enable also gated by valid.
    always_comb begin
        out_wdata = head_q.wdata;
        out_rd    = head_q.rd;
        out_zero  = head_q.zero;
        out_we    = out_valid & head_q.we;
        fwd_valid = out_we;
        fwd_rd    = out_rd;
        fwd_data  = out_wdata;
        stall_cnt = stall_cnt_q;
    end

endmodule
